// File: rtl/pipe_pkg.sv
// Shared types for the memory stage and its M->W pipeline register.
package pipe_pkg;

  typedef enum logic {
    MEM_IDLE = 1'b0,
    MEM_WAIT = 1'b1
  } mem_state_t;

  typedef struct packed {
    logic pcsrc;
    logic regwrite;
    logic memtoreg;
  } wb_ctrl_t;

  localparam wb_ctrl_t WB_BUBBLE = '{pcsrc: 1'b0, regwrite: 1'b0, memtoreg: 1'b0};

endpackage

// File: rtl/mw_pipereg.sv
// M->W pipeline register; a bubble clears the controls and holds the data fields.
module mw_pipereg
  import pipe_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              bubble,
  input  wb_ctrl_t          ctrl_d,
  input  logic [DATA_W-1:0] aluout_d,
  input  logic [DATA_W-1:0] rdata_d,
  input  logic [ADDR_W-1:0] waddr_d,
  output wb_ctrl_t          ctrl_q,
  output logic [DATA_W-1:0] aluout_q,
  output logic [DATA_W-1:0] rdata_q,
  output logic [ADDR_W-1:0] waddr_q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrl_q   <= WB_BUBBLE;
      aluout_q <= '0;
      rdata_q  <= '0;
      waddr_q  <= '0;
    end else if (bubble) begin
      ctrl_q   <= WB_BUBBLE;
    end else begin
      ctrl_q   <= ctrl_d;
      aluout_q <= aluout_d;
      rdata_q  <= rdata_d;
      waddr_q  <= waddr_d;
    end
  end

endmodule

// File: rtl/mem_stage.sv
// Memory pipeline stage: drives a wait-stated data memory over req/ready,
// stalls the front of the pipe while an access is outstanding, feeds writeback.
module mem_stage
  import pipe_pkg::*;
#(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              FlushM,
  input  logic              PCSrcM,
  input  logic              RegWriteM,
  input  logic              MemtoRegM,
  input  logic              MemWriteM,
  input  logic [DATA_W-1:0] ALUResultM,
  input  logic [DATA_W-1:0] WriteDataM,
  input  logic [3:0]        WriteAddrM,
  output logic              DataReq,
  output logic              DataWe,
  output logic [DATA_W-1:0] DataAddr,
  output logic [DATA_W-1:0] DataWdata,
  input  logic              DataReady,
  input  logic [DATA_W-1:0] DataRdata,
  output logic              MemStallM,
  output logic              MemFault,
  output logic              PCSrcW,
  output logic              RegWriteW,
  output logic              MemtoRegW,
  output logic [DATA_W-1:0] ReadDataW,
  output logic [DATA_W-1:0] ALUOutW,
  output logic [3:0]        WriteAddrW,
  output logic [DATA_W-1:0] ResultW
);

  localparam int unsigned     CNT_W    = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  mem_state_t        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              flushed_q, flushed_d;
  logic              fault_d;
  logic              bubble_c;
  logic              req_c;
  logic              stall_c;
  logic              mem_op;
  logic              aligned;
  logic              timeout_hit;
  logic              we_q;
  logic [DATA_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  wb_ctrl_t          ctrl_m;
  wb_ctrl_t          ctrl_w;

  assign mem_op      = MemtoRegM | MemWriteM;
  assign aligned     = (ALUResultM[1:0] == 2'b00);
  // Counter reads 0 in IDLE, so the first request cycle counts toward the limit.
  assign timeout_hit = (TIMEOUT != 0) && (cnt_q == CNT_LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= MEM_IDLE;
      cnt_q     <= '0;
      flushed_q <= 1'b0;
      MemFault  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      flushed_q <= flushed_d;
      MemFault  <= fault_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    flushed_d = flushed_q;
    fault_d   = 1'b0;
    bubble_c  = 1'b1;
    req_c     = 1'b0;
    stall_c   = 1'b0;
    case (state_q)
      MEM_IDLE: begin
        cnt_d     = '0;
        flushed_d = 1'b0;
        if (FlushM) begin
          bubble_c = 1'b1;
        end else if (mem_op && !aligned) begin
          fault_d = 1'b1;
        end else if (mem_op) begin
          req_c = 1'b1;
          if (DataReady) begin
            bubble_c = 1'b0;
          end else if (timeout_hit) begin
            fault_d = 1'b1;
          end else begin
            stall_c = 1'b1;
            state_d = MEM_WAIT;
            cnt_d   = CNT_W'(1);
          end
        end else begin
          bubble_c = 1'b0;
        end
      end
      MEM_WAIT: begin
        req_c = 1'b1;
        if (DataReady) begin
          bubble_c  = flushed_q | FlushM;
          state_d   = MEM_IDLE;
          cnt_d     = '0;
          flushed_d = 1'b0;
        end else if (timeout_hit) begin
          fault_d   = 1'b1;
          state_d   = MEM_IDLE;
          cnt_d     = '0;
          flushed_d = 1'b0;
        end else begin
          stall_c   = 1'b1;
          cnt_d     = cnt_q + CNT_W'(1);
          flushed_d = flushed_q | FlushM;
        end
      end
      default: state_d = MEM_IDLE;
    endcase
  end

  // Request fields captured at issue so they cannot move while waiting.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else if (state_q == MEM_IDLE) begin
      we_q    <= MemWriteM;
      addr_q  <= ALUResultM;
      wdata_q <= WriteDataM;
    end
  end

  assign DataReq   = reset & req_c;
  assign MemStallM = reset & stall_c;
  assign DataWe    = DataReq & ((state_q == MEM_WAIT) ? we_q : MemWriteM);
  assign DataAddr  = (state_q == MEM_WAIT) ? addr_q : ALUResultM;
  assign DataWdata = (state_q == MEM_WAIT) ? wdata_q : WriteDataM;

  assign ctrl_m = '{pcsrc: PCSrcM, regwrite: RegWriteM, memtoreg: MemtoRegM};

  mw_pipereg #(
    .DATA_W (DATA_W),
    .ADDR_W (4)
  ) u_mw_pipereg (
    .clk      (clk),
    .rst_n    (reset),
    .bubble   (bubble_c),
    .ctrl_d   (ctrl_m),
    .aluout_d (ALUResultM),
    .rdata_d  (DataRdata),
    .waddr_d  (WriteAddrM),
    .ctrl_q   (ctrl_w),
    .aluout_q (ALUOutW),
    .rdata_q  (ReadDataW),
    .waddr_q  (WriteAddrW)
  );

  assign PCSrcW    = ctrl_w.pcsrc;
  assign RegWriteW = ctrl_w.regwrite;
  assign MemtoRegW = ctrl_w.memtoreg;
  assign ResultW   = MemtoRegW ? ReadDataW : ALUOutW;

endmodule

// File: tb/tb_mem_stage.sv
// Directed self-checking bench for mem_stage with a 4-cycle timeout.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        FlushM, PCSrcM, RegWriteM, MemtoRegM, MemWriteM;
  logic [31:0] ALUResultM, WriteDataM;
  logic [3:0]  WriteAddrM;
  logic        DataReq, DataWe;
  logic [31:0] DataAddr, DataWdata;
  logic        DataReady;
  logic [31:0] DataRdata;
  logic        MemStallM, MemFault;
  logic        PCSrcW, RegWriteW, MemtoRegW;
  logic [31:0] ReadDataW, ALUOutW, ResultW;
  logic [3:0]  WriteAddrW;

  int checks   = 0;
  int failures = 0;

  mem_stage #(.DATA_W(32), .TIMEOUT(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .FlushM     (FlushM),
    .PCSrcM     (PCSrcM),
    .RegWriteM  (RegWriteM),
    .MemtoRegM  (MemtoRegM),
    .MemWriteM  (MemWriteM),
    .ALUResultM (ALUResultM),
    .WriteDataM (WriteDataM),
    .WriteAddrM (WriteAddrM),
    .DataReq    (DataReq),
    .DataWe     (DataWe),
    .DataAddr   (DataAddr),
    .DataWdata  (DataWdata),
    .DataReady  (DataReady),
    .DataRdata  (DataRdata),
    .MemStallM  (MemStallM),
    .MemFault   (MemFault),
    .PCSrcW     (PCSrcW),
    .RegWriteW  (RegWriteW),
    .MemtoRegW  (MemtoRegW),
    .ReadDataW  (ReadDataW),
    .ALUOutW    (ALUOutW),
    .WriteAddrW (WriteAddrW),
    .ResultW    (ResultW)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  // Drive the M-stage inputs and memory response in one go.
  task automatic drive(input logic fl, input logic pcs, input logic rw, input logic m2r,
                       input logic mw, input logic [31:0] alu, input logic [31:0] wd,
                       input logic [3:0] wa, input logic rdy, input logic [31:0] rd);
    FlushM     = fl;
    PCSrcM     = pcs;
    RegWriteM  = rw;
    MemtoRegM  = m2r;
    MemWriteM  = mw;
    ALUResultM = alu;
    WriteDataM = wd;
    WriteAddrM = wa;
    DataReady  = rdy;
    DataRdata  = rd;
  endtask

  task automatic nop();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 32'h0);
  endtask

  task automatic after_edge();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0;
    // A pending load on the M inputs must not raise a request while in reset.
    drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h100, 32'h0, 4'h1, 1'b0, 32'h0);
    #12;
    check("rst_req",      32'(DataReq),   32'd0);
    check("rst_stall",    32'(MemStallM), 32'd0);
    check("rst_fault",    32'(MemFault),  32'd0);
    check("rst_regwrite", 32'(RegWriteW), 32'd0);
    check("rst_result",   ResultW,        32'h0);
    check("rst_waddr",    32'(WriteAddrW),32'h0);

    @(negedge clk);
    reset = 1'b1;
    nop();

    // ALU op passes straight through to W
    @(negedge clk);
    drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h1234, 32'h0, 4'h3, 1'b0, 32'h0);
    #1;
    check("alu_req",   32'(DataReq),   32'd0);
    check("alu_stall", 32'(MemStallM), 32'd0);
    after_edge();
    check("alu_regwrite", 32'(RegWriteW), 32'd1);
    check("alu_pcsrc",    32'(PCSrcW),    32'd1);
    check("alu_result",   ResultW,        32'h1234);
    check("alu_waddr",    32'(WriteAddrW),32'h3);

    // Zero-wait load
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h100, 32'h0, 4'h5, 1'b1, 32'hCAFEF00D);
    #1;
    check("ld0_req",   32'(DataReq),   32'd1);
    check("ld0_we",    32'(DataWe),    32'd0);
    check("ld0_addr",  DataAddr,       32'h100);
    check("ld0_stall", 32'(MemStallM), 32'd0);
    after_edge();
    check("ld0_result",   ResultW,         32'hCAFEF00D);
    check("ld0_memtoreg", 32'(MemtoRegW),  32'd1);
    check("ld0_regwrite", 32'(RegWriteW),  32'd1);
    check("ld0_waddr",    32'(WriteAddrW), 32'h5);

    // Store with three wait states, ready on the fourth request cycle
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h200, 32'hDEADBEEF, 4'h7, (i == 3), 32'h0);
      #1;
      check("st_req",   32'(DataReq),   32'd1);
      check("st_we",    32'(DataWe),    32'd1);
      check("st_addr",  DataAddr,       32'h200);
      check("st_wdata", DataWdata,      32'hDEADBEEF);
      check("st_stall", 32'(MemStallM), (i < 3) ? 32'd1 : 32'd0);
      after_edge();
      check("st_regwrite", 32'(RegWriteW), 32'd0);
    end
    check("st_waddr", 32'(WriteAddrW), 32'h7);
    check("st_fault", 32'(MemFault),   32'd0);
    @(negedge clk);
    nop();
    #1;
    check("st_done_req", 32'(DataReq), 32'd0);

    // Misaligned store: no request, fault pulse, bubble
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32'h202, 32'h11, 4'h2, 1'b0, 32'h0);
    #1;
    check("mis_req",   32'(DataReq),   32'd0);
    check("mis_stall", 32'(MemStallM), 32'd0);
    after_edge();
    check("mis_fault",    32'(MemFault),  32'd1);
    check("mis_regwrite", 32'(RegWriteW), 32'd0);
    @(negedge clk);
    nop();
    after_edge();
    check("mis_fault_end", 32'(MemFault), 32'd0);

    // Load never ready: four request cycles, then abort
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h300, 32'h0, 4'h9, 1'b0, 32'h0);
      #1;
      check("to_req",   32'(DataReq),   32'd1);
      check("to_addr",  DataAddr,       32'h300);
      check("to_stall", 32'(MemStallM), (i < 3) ? 32'd1 : 32'd0);
      after_edge();
      check("to_fault",    32'(MemFault),  (i == 3) ? 32'd1 : 32'd0);
      check("to_regwrite", 32'(RegWriteW), 32'd0);
    end
    @(negedge clk);
    nop();
    #1;
    check("to_req_drop", 32'(DataReq),   32'd0);
    check("to_stall_end",32'(MemStallM), 32'd0);
    after_edge();
    check("to_fault_end", 32'(MemFault), 32'd0);

    // Flush in IDLE: no request, bubble replaces prior ALU result
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h77, 32'h0, 4'h4, 1'b0, 32'h0);
    after_edge();
    check("fli_pre_regwrite", 32'(RegWriteW), 32'd1);
    @(negedge clk);
    drive(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 32'h404, 32'h0, 4'h4, 1'b1, 32'h99);
    #1;
    check("fli_req", 32'(DataReq), 32'd0);
    after_edge();
    check("fli_regwrite", 32'(RegWriteW), 32'd0);
    check("fli_memtoreg", 32'(MemtoRegW), 32'd0);

    // Flush while waiting: transaction completes but result is dropped
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h400, 32'h0, 4'hA, 1'b0, 32'h0);
    #1;
    check("flw_stall0", 32'(MemStallM), 32'd1);
    after_edge();
    @(negedge clk);
    drive(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 32'h400, 32'h0, 4'hA, 1'b0, 32'h0);
    #1;
    check("flw_req_kept", 32'(DataReq),   32'd1);
    check("flw_stall1",   32'(MemStallM), 32'd1);
    after_edge();
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h400, 32'h0, 4'hA, 1'b1, 32'h55);
    #1;
    check("flw_req_done", 32'(DataReq),   32'd1);
    check("flw_stall2",   32'(MemStallM), 32'd0);
    after_edge();
    check("flw_regwrite", 32'(RegWriteW), 32'd0);
    check("flw_memtoreg", 32'(MemtoRegW), 32'd0);
    check("flw_fault",    32'(MemFault),  32'd0);

    // Reset mid-wait drops the request immediately and returns to IDLE
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h500, 32'h0, 4'hB, 1'b0, 32'h0);
    after_edge();
    @(negedge clk);
    #1;
    check("rw_req_before", 32'(DataReq), 32'd1);
    #2;
    reset = 1'b0;
    #1;
    check("rw_req_async",   32'(DataReq),   32'd0);
    check("rw_stall_async", 32'(MemStallM), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h600, 32'h0, 4'hC, 1'b1, 32'h600D);
    #1;
    check("rw_idle_req",   32'(DataReq),   32'd1);
    check("rw_idle_addr",  DataAddr,       32'h600);
    check("rw_idle_stall", 32'(MemStallM), 32'd0);
    after_edge();
    check("rw_result", ResultW, 32'h600D);
    check("rw_waddr",  32'(WriteAddrW), 32'hC);

    @(negedge clk);
    nop();
    after_edge();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
